// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges fetch-wait, load-use and divider hazards into
// the per-stage stall bus, sequences the EX divider and counts stall cycles.
module pipe_stall_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_wait,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_is_load,
  input  logic        ex_rf_we,
  input  logic [4:0]  ex_rf_waddr,
  input  logic        ex_div,
  input  logic        perf_clr,
  output logic [5:0]  stall,
  output logic        div_go,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] stall_cnt,
  output logic [15:0] loaduse_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [5:0]  r_cnt;
  logic [5:0]  w_cntNext;
  logic        r_busy;
  logic [31:0] r_stallCnt;
  logic [15:0] r_luCnt;

  logic        w_divGo;
  logic        w_divDone;
  logic        w_divStall;
  logic        w_loadUse;
  logic        w_luSel;
  logic [5:0]  w_stall;

  // RUN leaves for DONE on the cycle the count reaches zero, giving DIV_CYCLES stall cycles in total.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_divGo     = 1'b0;
    w_divDone   = 1'b0;
    w_divStall  = 1'b0;
    case (r_state)
      IDLE: begin
        if (ex_div) begin
          w_stateNext = RUN;
          w_cntNext   = 6'(DIV_CYCLES - 1);
          w_divGo     = 1'b1;
          w_divStall  = 1'b1;
        end
      end
      RUN: begin
        w_divStall = 1'b1;
        w_cntNext  = r_cnt - 6'd1;
        if (w_cntNext == 6'd0) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        w_divDone   = 1'b1;
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
    if (rst) begin
      w_divGo    = 1'b0;
      w_divDone  = 1'b0;
      w_divStall = 1'b0;
    end
  end

  always_comb begin
    w_loadUse = ex_is_load && ex_rf_we && (ex_rf_waddr != 5'd0) &&
                ((id_use_rs && (id_rs == ex_rf_waddr)) ||
                 (id_use_rt && (id_rt == ex_rf_waddr)));
    w_luSel   = 1'b0;
    w_stall   = 6'b000000;
    if (rst) begin
      w_stall = 6'b000000;
    end else if (w_divStall) begin
      w_stall = 6'b001111;
    end else if (w_loadUse) begin
      w_stall = 6'b000111;
      w_luSel = 1'b1;
    end else if (if_wait) begin
      w_stall = 6'b000011;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 6'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_busy  <= (w_stateNext != IDLE);
    end
  end

  // Clear wins over increment; load-use count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      r_stallCnt <= 32'd0;
      r_luCnt    <= 16'd0;
    end else begin
      if (w_stall != 6'd0) begin
        r_stallCnt <= r_stallCnt + 32'd1;
      end
      if (w_luSel && (r_luCnt != 16'hFFFF)) begin
        r_luCnt <= r_luCnt + 16'd1;
      end
    end
  end

  assign stall       = w_stall;
  assign div_go      = w_divGo;
  assign div_done    = w_divDone;
  assign div_busy    = r_busy;
  assign stall_cnt   = r_stallCnt;
  assign loaduse_cnt = r_luCnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a cycle-age reference model predicts every
// output each cycle, and a negedge monitor compares against the DUT.
module tb_pipe_stall_ctrl;
  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_wait = 1'b0;
  logic [4:0]  id_rs = 5'd0;
  logic [4:0]  id_rt = 5'd0;
  logic        id_use_rs = 1'b0;
  logic        id_use_rt = 1'b0;
  logic        ex_is_load = 1'b0;
  logic        ex_rf_we = 1'b0;
  logic [4:0]  ex_rf_waddr = 5'd0;
  logic        ex_div = 1'b0;
  logic        perf_clr = 1'b0;
  logic [5:0]  stall;
  logic        div_go;
  logic        div_busy;
  logic        div_done;
  logic [31:0] stall_cnt;
  logic [15:0] loaduse_cnt;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .if_wait(if_wait),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_is_load(ex_is_load), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_div(ex_div), .perf_clr(perf_clr),
    .stall(stall), .div_go(div_go), .div_busy(div_busy), .div_done(div_done),
    .stall_cnt(stall_cnt), .loaduse_cnt(loaduse_cnt)
  );

  typedef struct {
    logic       r;
    logic       iw;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       ld;
    logic       we;
    logic [4:0] wa;
    logic       dv;
    logic       pc;
  } stim_t;

  typedef struct {
    logic [5:0]  stall;
    logic        go;
    logic        busy;
    logic        done;
    logic [31:0] sc;
    logic [15:0] lc;
    bit          chkRegs;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: age of the divide in EX (-1 = none, 1..DC after launch).
  int          mAge = -1;
  bit          mBusy = 1'b0;
  logic [31:0] mSc = 32'd0;
  int          mLc = 0;
  bit          regsKnown = 1'b0;

  function automatic stim_t zeroStim();
    stim_t s;
    s.r = 1'b0; s.iw = 1'b0; s.rs = 5'd0; s.rt = 5'd0; s.urs = 1'b0; s.urt = 1'b0;
    s.ld = 1'b0; s.we = 1'b0; s.wa = 5'd0; s.dv = 1'b0; s.pc = 1'b0;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    exp_t       e;
    bit         go, dStall, done, lu, luSel;
    logic [5:0] pat;
    @(posedge clk);
    #1;
    rst = s.r; if_wait = s.iw; id_rs = s.rs; id_rt = s.rt;
    id_use_rs = s.urs; id_use_rt = s.urt; ex_is_load = s.ld; ex_rf_we = s.we;
    ex_rf_waddr = s.wa; ex_div = s.dv; perf_clr = s.pc;

    go     = !s.r && (mAge < 0) && s.dv;
    dStall = !s.r && (go || (mAge >= 1 && mAge < DC));
    done   = !s.r && (mAge == DC);
    lu     = s.ld && s.we && (s.wa != 5'd0) &&
             ((s.urs && s.rs == s.wa) || (s.urt && s.rt == s.wa));
    if (s.r)          pat = 6'b000000;
    else if (dStall)  pat = 6'b001111;
    else if (lu)      pat = 6'b000111;
    else if (s.iw)    pat = 6'b000011;
    else              pat = 6'b000000;
    luSel = !s.r && !dStall && lu;

    e.stall = pat; e.go = go; e.busy = mBusy; e.done = done;
    e.sc = mSc; e.lc = 16'(mLc); e.chkRegs = regsKnown;
    expQ.push_back(e);

    if (s.r) begin
      mAge = -1; mBusy = 1'b0; mSc = 32'd0; mLc = 0; regsKnown = 1'b1;
    end else begin
      if (go)              mAge = 1;
      else if (mAge == DC) mAge = -1;
      else if (mAge >= 1)  mAge = mAge + 1;
      mBusy = (mAge >= 1);
      if (s.pc) begin
        mSc = 32'd0; mLc = 0;
      end else begin
        if (pat != 6'd0) mSc = mSc + 32'd1;
        if (luSel && mLc < 65535) mLc = mLc + 1;
      end
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("stall", 32'(stall), 32'(e.stall));
    cmp("div_go", 32'(div_go), 32'(e.go));
    cmp("div_done", 32'(div_done), 32'(e.done));
    if (e.chkRegs) begin
      cmp("div_busy", 32'(div_busy), 32'(e.busy));
      cmp("stall_cnt", stall_cnt, e.sc);
      cmp("loaduse_cnt", 32'(loaduse_cnt), 32'(e.lc));
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  task automatic divRun(input int n, input stim_t base);
    stim_t s;
    s = base;
    s.dv = 1'b1;
    repeat (n) applyStimulus(s);
  endtask

  initial begin
    stim_t s;
    stim_t lu;
    int    waitCnt;

    $display("[TB] start, DIV_CYCLES=%0d", DC);

    // Reset held with a divide and fetch wait pending, then launch on release.
    s = zeroStim(); s.r = 1'b1; s.dv = 1'b1; s.iw = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    s = zeroStim(); s.iw = 1'b1;
    divRun(DC + 1, s);
    s = zeroStim();
    repeat (2) applyStimulus(s);

    // Load-use hit, then the two non-hazard variants.
    lu = zeroStim(); lu.ld = 1'b1; lu.we = 1'b1; lu.wa = 5'd8; lu.rs = 5'd8; lu.urs = 1'b1;
    applyStimulus(lu);
    s = lu; s.wa = 5'd0; s.rs = 5'd0; applyStimulus(s);
    s = lu; s.urs = 1'b0; applyStimulus(s);
    s = lu; s.urs = 1'b0; s.rt = 5'd8; s.urt = 1'b1; applyStimulus(s);

    // Priority: load-use over fetch wait, divide over both.
    s = lu; s.iw = 1'b1; applyStimulus(s);
    divRun(DC + 1, s);
    applyStimulus(zeroStim());

    // Reset in the middle of a divide.
    s = zeroStim();
    divRun(2, s);
    s.dv = 1'b1; s.r = 1'b1; applyStimulus(s);
    s = zeroStim(); repeat (DC + 2) applyStimulus(s);

    // Counter clear while a stall is active.
    s = zeroStim(); s.iw = 1'b1; repeat (3) applyStimulus(s);
    s.pc = 1'b1; applyStimulus(s);
    s = zeroStim(); repeat (2) applyStimulus(s);

    // Back-to-back divides with ex_div held high throughout.
    divRun(3 * (DC + 1), zeroStim());
    applyStimulus(zeroStim());

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      s.r   = ($urandom_range(0, 149) == 0);
      s.iw  = ($urandom_range(0, 3) == 0);
      s.rs  = 5'($urandom_range(0, 3));
      s.rt  = 5'($urandom_range(0, 3));
      s.urs = ($urandom_range(0, 1) == 0);
      s.urt = ($urandom_range(0, 1) == 0);
      s.ld  = ($urandom_range(0, 2) == 0);
      s.we  = ($urandom_range(0, 3) != 0);
      s.wa  = 5'($urandom_range(0, 3));
      s.dv  = ($urandom_range(0, 7) == 0);
      s.pc  = ($urandom_range(0, 59) == 0);
      applyStimulus(s);
    end

    // Drive load-use long enough to pin the counter at its ceiling.
    s = zeroStim(); s.pc = 1'b1; applyStimulus(s);
    repeat (65540) applyStimulus(lu);
    s = lu; s.iw = 1'b1; repeat (3) applyStimulus(s);
    s = zeroStim(); s.iw = 1'b1; s.pc = 1'b1; applyStimulus(s);
    applyStimulus(zeroStim());

    waitCnt = 0;
    while (expQ.size() > 0 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt = waitCnt + 1;
    end
    @(posedge clk);
    checks = checks + 1;
    if (expQ.size() != 0) begin
      errors = errors + 1;
      $display("[TB] FAIL drain actual=%0d required=0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central pipeline stall controller for the five-stage MIPS core. It merges the hazard sources into the shared `StallBus` consumed by every pipeline register, in this order:
- instruction-fetch wait;
- ID-stage load-use hazard;
- multi-cycle divide occupancy of EX.

It sequences the EX-stage divider through a fixed-latency state machine and keeps stall performance counters.

## Interface
Parameters:
- DIV_CYCLES, 32: cycles the divider needs after launch; legal range 2..63.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_wait  in  1  instruction SRAM not ready this cycle
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- ex_is_load  in  1  instruction in EX is a load (lw/lb/lbu/lh/lhu)
- ex_rf_we  in  1  EX instruction writes the register file
- ex_rf_waddr  in  5  EX destination register
- ex_div  in  1  instruction in EX is div/divu
- perf_clr  in  1  synchronous clear of performance counters
- stall  out  6  [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB, [5]=WB; 1=Stop
- div_go  out  1  one-cycle launch pulse to divider
- div_busy  out  1  divider occupied (registered)
- div_done  out  1  one-cycle pulse, quotient/remainder valid
- stall_cnt  out  32  cycles with stall≠0
- loaduse_cnt  out  16  cycles stalled by load-use

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE, ex_div=1: go to RUN; load cnt=DIV_CYCLES-1; div_go=1 in this cycle.
  - RUN: decrement cnt each cycle. When cnt==0, go to DONE.
  - DONE: div_done=1 and ex_div is ignored. Next state is IDLE.
- div_busy=1 in RUN and DONE.
- div_stall = (IDLE & ex_div) | RUN. It is 0 in DONE, so the div advances out of EX in the DONE cycle.
- load_use = ex_is_load & ex_rf_we & (ex_rf_waddr≠0) & ((id_use_rs & id_rs==ex_rf_waddr) | (id_use_rt & id_rt==ex_rf_waddr)).
- stall priority encode, combinational:
  - div_stall → 6'b001111: PC..EX held, bubble into MEM.
  - else load_use → 6'b000111: PC, IF/ID, ID held, bubble into EX.
  - else if_wait → 6'b000011: PC held, bubble into ID.
  - else 6'b000000.
- Because the encode is a priority, the bubble always lands in the lowest non-stopped stage.
- stall_cnt: +1 each cycle stall≠0, wraps at 2^32.
- loaduse_cnt: +1 each cycle the load-use term selects the stall pattern (not counted while div_stall masks it), saturates at 16'hFFFF.
- perf_clr zeroes both counters and has priority over increment in the same cycle. FSM is unaffected.

## Timing
- Reset values:
  - state=IDLE, cnt=0
  - div_busy=0, div_go=0, div_done=0
  - stall_cnt=0, loaduse_cnt=0
- stall is forced to 0 while rst=1.
- stall, div_go and div_done are combinational from registered state plus current inputs, so there is zero-cycle response.
- div_busy, the counters and state are registered.
- Divide occupancy: with ex_div rising in cycle T, stall=001111 for T..T+DIV_CYCLES-1 (DIV_CYCLES cycles), div_done=1 at T+DIV_CYCLES, and the div leaves EX at the end of T+DIV_CYCLES.
- Back-to-back divs: the second div enters EX at T+DIV_CYCLES+1, when state is IDLE, and launches normally.
- Load-use costs exactly one cycle: the load moves to MEM, so load_use drops and the ID stall ends.
- rst asserted in RUN: next cycle IDLE, div_done is not pulsed, and no stall is issued during reset.

## Test plan
- Reset: hold rst 2 cycles with ex_div=1, if_wait=1 → stall=0, div_busy=0, both counters 0; after release, stall=001111 the same cycle.
- Divide, DIV_CYCLES=4: ex_div=1 at T → div_go at T only; stall=001111 at T..T+3; div_done=1, stall=0 at T+4; div_busy=1 at T+1..T+4; stall_cnt=4.
- Load-use: ex_is_load=1, ex_rf_we=1, ex_rf_waddr=8, id_rs=8, id_use_rs=1 → stall=000111, loaduse_cnt +1.
  - Same with ex_rf_waddr=0 → stall=0.
  - Same with id_use_rs=0 → stall=0.
- Priority: if_wait=1 with load_use=1 → 000111. Add ex_div=1 → 001111, and loaduse_cnt does not increment.
- Reset mid-divide: rst at T+2 of a DIV_CYCLES=8 run → IDLE at T+3, div_done never pulses, stall=0 during rst.
- Counters: preload stall_cnt near 2^32-1 via 2^32 forced stall cycles (or force) → wraps to 0. Saturate loaduse_cnt at FFFF. perf_clr with active stall → both read 0 next cycle.
